// File: rtl/arm_ctrl_pkg.sv
// Shared state, opcode and IR-field helpers for the
// ARM-subset multicycle controller.
package arm_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        K_DP,
        K_LDR,
        K_STR
    } kind_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;

    // {I,P,U,B,W,L} patterns of the two legal memory forms
    localparam logic [5:0] LDR_BITS = 6'b011001;
    localparam logic [5:0] STR_BITS = 6'b111000;

    localparam int NREG = 15;
    localparam int MAXW = 64;

    function automatic logic [1:0] f_op(input logic [31:0] ir);
        return ir[27:26];
    endfunction

    function automatic logic [5:0] f_mbits(input logic [31:0] ir);
        return ir[25:20];
    endfunction

    function automatic logic f_imm(input logic [31:0] ir);
        return ir[25];
    endfunction

    function automatic logic [3:0] f_cmd(input logic [31:0] ir);
        return ir[24:21];
    endfunction

    function automatic logic [3:0] f_rn(input logic [31:0] ir);
        return ir[19:16];
    endfunction

    function automatic logic [3:0] f_rd(input logic [31:0] ir);
        return ir[15:12];
    endfunction

    function automatic logic [3:0] f_rm(input logic [31:0] ir);
        return ir[3:0];
    endfunction

    function automatic logic [11:0] f_imm12(input logic [31:0] ir);
        return ir[11:0];
    endfunction

    function automatic logic [3:0] f_rot(input logic [31:0] ir);
        return ir[11:8];
    endfunction

    function automatic logic [7:0] f_imm8(input logic [31:0] ir);
        return ir[7:0];
    endfunction

    // Rotate right by 2*rot within the low dw bits; upper bits stay zero.
    function automatic logic [MAXW-1:0] ror_imm(
        input logic [7:0]  imm8,
        input logic [3:0]  rot,
        input int unsigned dw
    );
        logic [MAXW-1:0] r;
        int unsigned     s;
        int unsigned     j;
        r = '0;
        s = {27'd0, rot, 1'b0};
        for (int unsigned i = 0; i < MAXW; i++) begin
            j = (i + s) % dw;
            if (i < dw && j < 8) r[i] = imm8[j[2:0]];
        end
        return r;
    endfunction

endpackage

// File: rtl/arm_regfile.sv
// General registers r0-r14: two async read ports, one sync write port.
// Index 15 (the PC) is not stored here and reads back as zero.
module arm_regfile
    import arm_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [3:0]    rb_addr,
    output logic [DW-1:0] rb_data,
    input  logic          we,
    input  logic [3:0]    wa,
    input  logic [DW-1:0] wd
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && wa < 4'(NREG)) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data = (ra_addr < 4'(NREG)) ? regs[ra_addr] : '0;
    assign rb_data = (rb_addr < 4'(NREG)) ? regs[rb_addr] : '0;

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM-subset controller: owns PC and register file and
// sequences fetch/decode/exec/mem/wb over a req/ack memory port.
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int            DW       = 32,
    parameter int            AW       = 8,
    parameter logic [DW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_cmd,
    input  logic [DW-1:0] alu_y,
    output logic          halted,
    output logic [31:0]   retired
);

    state_t          state;
    kind_t           kind;
    logic [31:0]     ir;
    logic [DW-1:0]   pc;
    logic [DW-1:0]   wb_val;

    logic [3:0]      rb_addr;
    logic [DW-1:0]   ra_data;
    logic [DW-1:0]   rb_data;
    logic [DW-1:0]   rn_val;
    logic [DW-1:0]   rb_val;
    logic [MAXW-1:0] imm_full;
    logic [DW-1:0]   imm_dw;
    logic [DW-1:0]   offset;
    logic [DW-1:0]   addr_sum;
    logic            rf_we;
    logic            unused_bits;

    // Port B reads Rm for operands/offsets and Rd as store data in MEM
    assign rb_addr = (state == MEM) ? f_rd(ir) : f_rm(ir);

    assign rn_val = (f_rn(ir) == 4'd15) ? pc : ra_data;
    assign rb_val = (rb_addr == 4'd15) ? pc : rb_data;

    assign imm_full = ror_imm(f_imm8(ir), f_rot(ir), DW);
    assign imm_dw   = imm_full[DW-1:0];

    assign offset   = (kind == K_LDR) ? DW'(f_imm12(ir)) : rb_val;
    assign addr_sum = rn_val + offset;

    assign rf_we   = (state == WB) && (f_rd(ir) != 4'd15);
    assign alu_cmd = f_cmd(ir);

    assign unused_bits = ^{imm_full, ir[31:28]};

    arm_regfile #(
        .DW(DW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (f_rn(ir)),
        .ra_data (ra_data),
        .rb_addr (rb_addr),
        .rb_data (rb_data),
        .we      (rf_we),
        .wa      (f_rd(ir)),
        .wd      (wb_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            kind      <= K_DP;
            ir        <= '0;
            pc        <= RESET_PC;
            wb_val    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            halted    <= 1'b0;
            retired   <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= pc[AW-1:0];
                        mem_wdata <= '0;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        ir      <= 32'(mem_rdata);
                        pc      <= pc + DW'(1);
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    unique case (1'b1)
                        (f_op(ir) == OP_DP): begin
                            kind  <= K_DP;
                            alu_a <= rn_val;
                            alu_b <= f_imm(ir) ? imm_dw : rb_val;
                            state <= EXEC;
                        end
                        (f_op(ir) == OP_MEM &&
                         f_mbits(ir) == LDR_BITS): begin
                            kind  <= K_LDR;
                            state <= EXEC;
                        end
                        (f_op(ir) == OP_MEM &&
                         f_mbits(ir) == STR_BITS): begin
                            kind  <= K_STR;
                            state <= EXEC;
                        end
                        default: begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                    endcase
                end
                EXEC: begin
                    if (kind == K_DP) begin
                        wb_val <= alu_y;
                        state  <= WB;
                    end else begin
                        mem_addr <= addr_sum[AW-1:0];
                        state    <= MEM;
                    end
                end
                MEM: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (kind == K_STR);
                        mem_wdata <= (kind == K_STR) ? rb_val : '0;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (kind == K_STR) begin
                            retired <= retired + 32'd1;
                            state   <= FETCH;
                        end else begin
                            wb_val <= mem_rdata;
                            state  <= WB;
                        end
                    end
                end
                WB: begin
                    if (f_rd(ir) == 4'd15) pc <= wb_val;
                    retired <= retired + 32'd1;
                    state   <= FETCH;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed bench for arm_multicycle_ctrl with a waitable memory
// model and a small combinational ALU.
module tb_arm_multicycle_ctrl;

    localparam int          DW  = 32;
    localparam int          AW  = 8;
    localparam logic [31:0] RPC = 32'h0;
    localparam logic [31:0] HLT = 32'hE800_0000;
    localparam logic [3:0]  ADD = 4'h4;
    localparam logic [3:0]  ORR = 4'hC;
    localparam logic [3:0]  MOV = 4'hD;

    logic          clk;
    logic          rst_n;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_cmd;
    logic [DW-1:0] alu_y;
    logic          halted;
    logic [31:0]   retired;

    int            checks;
    int            failures;
    int            waits;
    bit            hold_ack;
    int            wcnt;
    int            wr_cnt;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [AW-1:0] rd_log [$];
    int            cyc;
    int            ret_cyc [$];
    logic [31:0]   last_ret;
    logic [31:0]   mem [256];

    arm_multicycle_ctrl #(
        .DW(DW),
        .AW(AW),
        .RESET_PC(RPC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cmd   (alu_cmd),
        .alu_y     (alu_y),
        .halted    (halted),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_cmd)
            ADD:     alu_y = alu_a + alu_b;
            ORR:     alu_y = alu_a | alu_b;
            MOV:     alu_y = alu_b;
            default: alu_y = alu_a ^ alu_b;
        endcase
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req && !hold_ack) begin
            if (wcnt < waits) begin
                wcnt++;
            end else begin
                wcnt    = 0;
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    wr_cnt++;
                    wr_addr = mem_addr;
                    wr_data = mem_wdata;
                end else begin
                    mem_rdata = mem[mem_addr];
                    rd_log.push_back(mem_addr);
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst_n && retired != last_ret) ret_cyc.push_back(cyc);
        last_ret = retired;
    end

    function automatic logic [31:0] dp(
        input bit i, input logic [3:0] cmd,
        input logic [3:0] rn, input logic [3:0] rd,
        input logic [11:0] op2);
        return {4'hE, 2'b00, i, cmd, 1'b0, rn, rd, op2};
    endfunction

    function automatic logic [31:0] ldr(
        input logic [3:0] rn, input logic [3:0] rd,
        input logic [11:0] imm);
        return {4'hE, 2'b01, 6'b011001, rn, rd, imm};
    endfunction

    function automatic logic [31:0] str(
        input logic [3:0] rn, input logic [3:0] rd,
        input logic [3:0] rm);
        return {4'hE, 2'b01, 6'b111000, rn, rd, 8'h00, rm};
    endfunction

    task automatic clear_mem;
        for (int i = 0; i < 256; i++) mem[i] = HLT;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        rd_log.delete();
        ret_cyc.delete();
        wr_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(input int max, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < max && !ok; n++) begin
            @(posedge clk);
            #1;
            ok = halted;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, halted} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=000",
                     {mem_req, mem_we, halted});
        end
        checks++;
        if (alu_b !== 32'h0 || alu_a !== 32'h0) begin
            failures++;
            $display("FAIL reset_alu got=%h/%h exp=0", alu_a, alu_b);
        end
        checks++;
        if (retired !== 32'h0) begin
            failures++;
            $display("FAIL reset_retired got=%0d exp=0", retired);
        end
        checks++;
        if (dut.u_rf.regs[6] !== 32'h0) begin
            failures++;
            $display("FAIL reset_r6 got=%h exp=0", dut.u_rf.regs[6]);
        end
        checks++;
        if (dut.pc !== RPC) begin
            failures++;
            $display("FAIL reset_pc got=%h exp=%h", dut.pc, RPC);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_dp_imm;
        clear_mem();
        mem[0] = dp(1'b1, ADD, 4'd0, 4'd6, {4'd1, 8'h01});
        waits  = 0;
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (alu_b !== 32'h4000_0000 || alu_cmd !== ADD) begin
            failures++;
            $display("FAIL dp_alu_b got=%h cmd=%h exp=40000000 cmd=4",
                     alu_b, alu_cmd);
        end
        @(posedge clk);
        #1;
        checks++;
        if (retired !== 32'd0 || dut.u_rf.regs[6] !== 32'h0) begin
            failures++;
            $display("FAIL dp_early got=%0d/%h exp=0/0",
                     retired, dut.u_rf.regs[6]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (retired !== 32'd1 || dut.u_rf.regs[6] !== 32'h4000_0000) begin
            failures++;
            $display("FAIL dp_wb5 got=%0d/%h exp=1/40000000",
                     retired, dut.u_rf.regs[6]);
        end
    endtask

    task automatic test_str;
        bit ok;
        clear_mem();
        mem[0]    = dp(1'b1, MOV, 4'd0, 4'd1, 12'h003);
        mem[1]    = dp(1'b1, MOV, 4'd0, 4'd3, 12'h004);
        mem[2]    = ldr(4'd0, 4'd2, 12'h040);
        mem[3]    = str(4'd1, 4'd2, 4'd3);
        mem[8'h40] = 32'hDEAD_BEEF;
        waits = 0;
        do_reset();
        run_to_halt(200, ok);
        checks++;
        if (!ok || retired !== 32'd4) begin
            failures++;
            $display("FAIL str_run got=%0d/%0d exp=1/4", ok, retired);
        end
        checks++;
        if (wr_cnt !== 1 || wr_addr !== 8'd7 ||
            wr_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL str_write got=%0d@%h=%h exp=1@07=deadbeef",
                     wr_cnt, wr_addr, wr_data);
        end
        checks++;
        if (ret_cyc.size() != 4) begin
            failures++;
            $display("FAIL str_retires got=%0d exp=4", ret_cyc.size());
        end else if (ret_cyc[3] - ret_cyc[2] != 6 ||
                     ret_cyc[2] - ret_cyc[1] != 7) begin
            failures++;
            $display("FAIL str_latency got=%0d/%0d exp=7/6",
                     ret_cyc[2] - ret_cyc[1], ret_cyc[3] - ret_cyc[2]);
        end
    endtask

    task automatic test_ldr(input int w);
        bit ok;
        int exp_lat;
        exp_lat = (w == 0) ? 7 : 13;
        clear_mem();
        mem[0]     = dp(1'b1, MOV, 4'd0, 4'd4, 12'h01C);
        mem[1]     = ldr(4'd4, 4'd5, 12'h004);
        mem[8'h20] = 32'h1234_5678;
        waits = w;
        do_reset();
        run_to_halt(300, ok);
        checks++;
        if (!ok || dut.u_rf.regs[5] !== 32'h1234_5678) begin
            failures++;
            $display("FAIL ldr_r5 w=%0d got=%h exp=12345678",
                     w, dut.u_rf.regs[5]);
        end
        checks++;
        if (ret_cyc.size() != 2) begin
            failures++;
            $display("FAIL ldr_retires got=%0d exp=2", ret_cyc.size());
        end else if (ret_cyc[1] - ret_cyc[0] != exp_lat) begin
            failures++;
            $display("FAIL ldr_latency w=%0d got=%0d exp=%0d",
                     w, ret_cyc[1] - ret_cyc[0], exp_lat);
        end
        waits = 0;
    endtask

    task automatic test_branch;
        bit ok;
        clear_mem();
        mem[0]     = dp(1'b1, MOV, 4'd0, 4'd15, 12'h010);
        mem[1]     = dp(1'b1, MOV, 4'd0, 4'd7, 12'h033);
        mem[8'h10] = dp(1'b1, MOV, 4'd0, 4'd7, 12'h055);
        do_reset();
        run_to_halt(200, ok);
        checks++;
        if (rd_log.size() < 2) begin
            failures++;
            $display("FAIL br_fetches got=%0d exp>=2", rd_log.size());
        end else if (rd_log[1] !== 8'h10) begin
            failures++;
            $display("FAIL br_target got=%h exp=10", rd_log[1]);
        end
        checks++;
        if (!ok || dut.u_rf.regs[7] !== 32'h55 || retired !== 32'd2) begin
            failures++;
            $display("FAIL br_result got=%h/%0d exp=55/2",
                     dut.u_rf.regs[7], retired);
        end
    endtask

    task automatic test_halt;
        bit ok;
        int req_seen;
        clear_mem();
        do_reset();
        run_to_halt(50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL halt_set got=%b exp=1", halted);
        end
        req_seen = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (mem_req) req_seen++;
        end
        checks++;
        if (req_seen != 0 || halted !== 1'b1 || retired !== 32'd0) begin
            failures++;
            $display("FAIL halt_quiet got=%0d/%b/%0d exp=0/1/0",
                     req_seen, halted, retired);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || dut.pc !== RPC) begin
            failures++;
            $display("FAIL halt_reset got=%b/%h exp=0/%h",
                     halted, dut.pc, RPC);
        end
        @(posedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok;
        clear_mem();
        mem[0]     = dp(1'b1, MOV, 4'd0, 4'd15, 12'h010);
        mem[8'h10] = dp(1'b1, MOV, 4'd0, 4'd8, 12'h077);
        do_reset();
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(posedge clk);
            #1;
            ok = (retired == 32'd1);
        end
        hold_ack = 1'b1;
        for (int n = 0; n < 10 && !mem_req; n++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (!ok || mem_req !== 1'b1 || mem_addr !== 8'h10) begin
            failures++;
            $display("FAIL mid_req got=%b@%h exp=1@10", mem_req, mem_addr);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL mid_drop got=%b exp=0", mem_req);
        end
        hold_ack = 1'b0;
        do_reset();
        run_to_halt(200, ok);
        checks++;
        if (rd_log.size() < 1) begin
            failures++;
            $display("FAIL mid_refetch got=none exp=%h", RPC[AW-1:0]);
        end else if (rd_log[0] !== RPC[AW-1:0]) begin
            failures++;
            $display("FAIL mid_refetch got=%h exp=%h",
                     rd_log[0], RPC[AW-1:0]);
        end
        checks++;
        if (!ok || dut.u_rf.regs[8] !== 32'h77 || retired !== 32'd2) begin
            failures++;
            $display("FAIL mid_rerun got=%h/%0d exp=77/2",
                     dut.u_rf.regs[8], retired);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        waits     = 0;
        hold_ack  = 1'b0;
        wr_cnt    = 0;
        wr_addr   = '0;
        wr_data   = '0;
        last_ret  = '0;
        cyc       = 0;
        clear_mem();
        test_reset();
        test_dp_imm();
        test_reset();
        test_str();
        test_ldr(0);
        test_ldr(3);
        test_branch();
        test_halt();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arm_multicycle_ctrl.md
# arm_multicycle_ctrl

Parametrised multicycle controller for the ARM-subset CPU: owns the register file and PC and sequences each instruction through fetch, decode, execute, memory and writeback. It runs against a single-port memory through a req/ack handshake and drives an external combinational ALU. Reset, waited memory, true immediate rotation, PC writes and illegal-instruction halt are all defined here.

## Interface
- DW, 32: datapath and register width (≥ 16).
- AW, 8: memory word-address width.
- RESET_PC, 0: PC value loaded on reset.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory request; held until acknowledged.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  AW  word address; valid while mem_req.
- mem_wdata  out  DW  store data; valid while mem_req && mem_we.
- mem_rdata  in  DW  read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  transfer completes at the clock edge where mem_req && mem_ack.
- alu_a, alu_b  out  DW  ALU operands.
- alu_cmd  out  4  instruction[24:21].
- alu_y  in  DW  combinational ALU result.
- halted  out  1  sticky; set on illegal instruction.
- retired  out  32  count of completed instructions; wraps.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Register file: r0–r14 general, r15 = PC. PC is DW wide. mem_addr takes PC[AW-1:0].
- The condition field [31:28] is ignored. Every instruction executes.
- FETCH: issue a read at PC. On ack, latch IR and set PC ← PC+1, then go to DECODE.
- DECODE classifies IR:
  - op=00: data processing. Go to EXEC.
  - op=01 with I=0, P=1, U=1, B=0, W=0, L=1: LDR, address Rn+imm12. Go to EXEC.
  - op=01 with I=1, P=1, U=1, B=0, W=0, L=0: STR, address Rn+Rm. Go to EXEC.
  - Anything else: set halted and go to HALT.
- Reading r15 returns the already-incremented PC.
- EXEC:
  - Data processing: alu_a = Rn. alu_b = Rm if I=0, else zero-extended imm8 rotated right by 2·rot within DW bits (true rotate). Register alu_y, then go to WB.
  - LDR/STR: register the address as (Rn + offset)[AW-1:0], then go to MEM.
- MEM: issue the request.
  - LDR: read. On ack, latch mem_rdata and go to WB.
  - STR: write with mem_wdata = Rd. On ack, increment retired and go to FETCH.
- WB: Rd ← latched value. If Rd=15, PC is overwritten, which acts as a branch. Increment retired and go to FETCH.
- HALT: absorbing. Only reset leaves it. mem_req stays 0.
- Reset values: all registers 0, PC = RESET_PC, state = FETCH, retired = 0, halted = 0. All outputs are 0 during reset.

## Timing
- mem_req rises on the clock edge after entering FETCH or MEM. A zero-wait ack is allowed in that same cycle.
- mem_req, mem_we, mem_addr and mem_wdata stay stable until the ack edge. mem_req drops the cycle after ack.
- Requests are never issued back to back. There is at least one cycle with mem_req=0 between transfers.
- Latencies with zero-wait memory, counted from FETCH entry to the next FETCH entry:
  - data processing: 5 cycles;
  - STR: 6 cycles;
  - LDR: 7 cycles.
- Each memory wait cycle adds one cycle.
- An rst_n assertion mid-transfer drops mem_req asynchronously. An ack arriving during reset is ignored.
- retired increments on the same edge that returns to FETCH.
- An instruction that writes r15 makes the next FETCH use the written value. No stale prefetch exists.

## Structure
- Shared package arm_ctrl_pkg holds:
  - the state enum;
  - op encodings (OP_DP=2'b00, OP_MEM=2'b01);
  - IR field-extraction functions;
  - the LDR/STR match constants;
  - the ror_imm function.
- Sub-module arm_regfile: 15 × DW registers r0–r14, two asynchronous read ports, one synchronous write port, asynchronous reset to 0. PC stays in the controller.

## Test plan
- Reset, then a data-processing instruction (I=1, Rn=r0, imm8=0x01, rot=1; memory at 0) with zero-wait ack.
  - alu_b = 0x40000000.
  - Rd is written at 5 cycles.
  - retired = 1.
- r1=3, STR r2 via Rn=r1 + Rm=r3 with r3=4 and r2=0xDEADBEEF.
  - One request with mem_we=1, mem_addr=7, mem_wdata=0xDEADBEEF.
- Preload mem[0x20]=0x12345678 with r4=0x1C, then LDR r5, [r4,#4].
  - r5=0x12345678 after 7 cycles.
  - With 3 wait states on each transfer, it takes 13 cycles.
- Data-processing instruction with Rd=15 writing 0x10.
  - The next FETCH mem_addr = 0x10.
- Instruction op=2'b10.
  - halted=1 and mem_req stays 0 for 100 cycles.
  - After rst_n pulses, halted=0 and PC = RESET_PC.
- rst_n asserted while mem_req=1 and ack is withheld.
  - mem_req is 0 in the same cycle.
  - After release, fetch restarts at RESET_PC.
